cnn_layer_accel_macc_chain: RTL and testbench
=============================================

Name: cnn_layer_accel_macc_chain

Overview:
- Parametrised successor to the single-tap MACC cell: C_NUM_TAPS multiply (or squared-difference) taps, cascaded through a partial-sum chain, with a tail accumulator that sums a runtime-programmable number of input beats per result.
- Adds valid/ready handshakes with full-pipeline stall, a per-group overflow flag and a runtime mode select.
- Sits between the convolution window buffers and the output/requant stage of the layer accelerator.

Parameters:
- C_NUM_TAPS, 4, number of taps (>=1).
- C_DSP_INPUT_WIDTH, 18, signed operand width W per tap.
- C_DSP_OUTPUT_WIDTH, 48, signed chain/accumulator/result width P (P >= 2W+2).
- C_ACCUM_LEN_WIDTH, 16, width of cfg_accum_len.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  1  0 = a*b, 1 = (a-b)^2.
- cfg_accum_len  in  C_ACCUM_LEN_WIDTH  beats per result; 0 treated as 1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  C_NUM_TAPS*W  signed operands; tap i at [i*W +: W].
- b  in  C_NUM_TAPS*W  signed operands; same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  P  signed accumulated result.
- out_ovf  out  1  signed overflow occurred within this result's group.
- busy  out  1  any beat in flight, or accumulator count != 0.

Behaviour:
- Reset: asynchronous. All registers clear to 0: out_valid, out_data, out_ovf, all stage valids, accumulator, count. in_ready=1 and busy=0 after reset.
- Enable: en = !out_valid || out_ready; in_ready = en. Every pipeline register, including valid bits, advances only when en=1. A beat is accepted when in_valid && in_ready. Bubbles propagate as invalid stages.
- Tap i datapath:
  - S0 input register, then i skew registers.
  - Pre-adder register: a-b sign-extended to W+1 in mode 1; a sign-extended in mode 0.
  - M register: pre*pre in mode 1; a*b in mode 0; sign-extended to P.
  - P register: M + pcin, where pcin = 0 for tap 0 and P of tap i-1 otherwise. The skew aligns the taps.
  - The P of the last tap is the beat sum.
- Accumulator stage, on a valid beat sum:
  - If count==0: acc = sum; ovf = 0; the latched length L is taken from cfg_accum_len.
  - Otherwise: acc = acc + sum, wrapping modulo 2^P. ovf |= signed overflow of that add, meaning both operands share a sign and the result sign differs.
  - count increments. When count reaches L-1: out_data <= new acc, out_ovf <= new ovf, out_valid <= 1, count <= 0.
- Latency: if the last beat of a group is accepted at edge k and no stalls occur, out_valid rises at edge k+C_NUM_TAPS+3 (7 for the defaults). Throughput is 1 beat/cycle. A fully stalled group produces no loss or duplication.
- Output: out_data and out_ovf hold stable while out_valid && !out_ready. out_valid clears on the handshake unless a new result loads the same edge; back-to-back results are allowed with out_ready held high.
- cfg_mode must be stable while busy=1. Changing it mid-flight is a usage error and the result is undefined. cfg_accum_len may change anytime; it is sampled only at the group start.
- Reset mid-group: everything in flight is discarded. The first post-reset beat starts a fresh group.

Test Plan:
- Mode 0, len 1, a={1,2,3,4}, b={5,6,7,8} accepted at edge k -> out_valid at edge k+7, out_data=70, out_ovf=0.
- Mode 1, len 1, a={10,-3,0,5}, b={7,4,0,-5} -> diffs 3,-7,0,10 -> out_data=158.
- Mode 0, len 3, three back-to-back beats each summing 70, then a fourth beat with len 1 -> out_data=210 for exactly one output beat, then a separate result of 70. No accumulation carries across groups.
- Backpressure: two results pending with out_ready=0 -> in_ready=0 and out_data stable at the first result. Raise out_ready -> both results delivered in order, with no beat lost.
- P=40, mode 0, len 8, all a=b=-131072 -> sum 2^39 wraps to out_data=-2^39 with out_ovf=1. The next group of a=b=1, len 1 gives out_data=4, out_ovf=0.
- Assert rst asynchronously mid-group (count=2, pipeline full) -> out_valid, busy and out_data are 0 immediately without a clock edge. A subsequent len-1 beat gives the correct 70.

Source files
------------

// File: rtl/cnn_layer_accel_macc_chain.sv
// Multi-tap MACC chain: per-tap multiply or squared difference, skew-aligned partial-sum cascade,
// and a tail accumulator that folds a programmable number of beats into each result.
module cnn_layer_accel_macc_chain #(
  parameter int C_NUM_TAPS         = 4,
  parameter int C_DSP_INPUT_WIDTH  = 18,
  parameter int C_DSP_OUTPUT_WIDTH = 48,
  parameter int C_ACCUM_LEN_WIDTH  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_mode,
  input  logic [C_ACCUM_LEN_WIDTH-1:0]              cfg_accum_len,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [C_NUM_TAPS*C_DSP_INPUT_WIDTH-1:0]   a,
  input  logic [C_NUM_TAPS*C_DSP_INPUT_WIDTH-1:0]   b,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [C_DSP_OUTPUT_WIDTH-1:0]      out_data,
  output logic                                      out_ovf,
  output logic                                      busy
);

  localparam int N  = C_NUM_TAPS;
  localparam int W  = C_DSP_INPUT_WIDTH;
  localparam int P  = C_DSP_OUTPUT_WIDTH;
  localparam int LW = C_ACCUM_LEN_WIDTH;
  // S0 + pre + M + P for tap 0, plus one extra stage per downstream tap
  localparam int D  = N + 3;

  logic         en;
  logic [D-1:0] vld;
  logic [N-1:0][P-1:0] p_chain;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else if (en) vld <= {vld[D-2:0], in_valid};
  end

  for (genvar i = 0; i < N; i++) begin : g_tap
    logic signed [W-1:0]     a_sr [i+1];
    logic signed [W-1:0]     b_sr [i+1];
    logic signed [W:0]       a_ext, b_ext, pre_d, pre_q, b_q;
    logic signed [2*W+1:0]   prod;
    logic signed [P-1:0]     m_q, p_q, pcin;

    if (i == 0) begin : g_head
      assign pcin = '0;
    end else begin : g_link
      assign pcin = $signed(p_chain[i-1]);
    end

    always_comb begin
      a_ext = {a_sr[i][W-1], a_sr[i]};
      b_ext = {b_sr[i][W-1], b_sr[i]};
      pre_d = cfg_mode ? (a_ext - b_ext) : a_ext;
      prod  = cfg_mode ? (pre_q * pre_q) : (pre_q * b_q);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          a_sr[j] <= '0;
          b_sr[j] <= '0;
        end
        pre_q <= '0;
        b_q   <= '0;
        m_q   <= '0;
        p_q   <= '0;
      end else if (en) begin
        a_sr[0] <= a[i*W +: W];
        b_sr[0] <= b[i*W +: W];
        for (int j = 1; j <= i; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
        end
        pre_q <= pre_d;
        b_q   <= b_ext;
        m_q   <= P'(prod);
        p_q   <= m_q + pcin;
      end
    end

    assign p_chain[i] = p_q;
  end

  logic [LW-1:0]       count, len_q, len_cfg, len_eff;
  logic signed [P-1:0] acc, sum, acc_sum, acc_new;
  logic                ovf, ovf_new, add_ovf, last;

  always_comb begin
    sum     = $signed(p_chain[N-1]);
    len_cfg = (cfg_accum_len == '0) ? LW'(1) : cfg_accum_len;
    len_eff = (count == '0) ? len_cfg : len_q;
    acc_sum = acc + sum;
    add_ovf = (acc[P-1] == sum[P-1]) && (acc_sum[P-1] != acc[P-1]);
    acc_new = acc_sum;
    ovf_new = ovf | add_ovf;
    if (count == '0) begin
      acc_new = sum;
      ovf_new = 1'b0;
    end
    last = (count == len_eff - LW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      len_q     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      // en implies the current result (if any) is being taken this edge
      out_valid <= 1'b0;
      if (vld[D-1]) begin
        acc <= acc_new;
        ovf <= ovf_new;
        if (count == '0) len_q <= len_cfg;
        if (last) begin
          count     <= '0;
          out_data  <= acc_new;
          out_ovf   <= ovf_new;
          out_valid <= 1'b1;
        end else begin
          count <= count + LW'(1);
        end
      end
    end
  end

  assign busy = (|vld) || (count != '0);

endmodule

// File: tb/tb_cnn_layer_accel_macc_chain.sv
// Scoreboard bench for the MACC chain: stimulus pushes expected results, a monitor pops on handshake.
module tb_cnn_layer_accel_macc_chain;
  localparam int N  = 4;
  localparam int W  = 18;
  localparam int P  = 40;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_mode = 1'b0;
  logic [LW-1:0]     cfg_accum_len = 16'd1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*W-1:0]    a = '0;
  logic [N*W-1:0]    b = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [P-1:0] out_data;
  logic              out_ovf;
  logic              busy;

  typedef struct { longint data; logic ovf; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  cnn_layer_accel_macc_chain #(
    .C_NUM_TAPS(N), .C_DSP_INPUT_WIDTH(W), .C_DSP_OUTPUT_WIDTH(P), .C_ACCUM_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_accum_len(cfg_accum_len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pk(int v0, int v1, int v2, int v3);
    pk = {18'(v3), 18'(v2), 18'(v1), 18'(v0)};
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(longint d, logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  task automatic send(logic [N*W-1:0] av, logic [N*W-1:0] bv);
    int t = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", longint'(out_data), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_data", longint'(out_data), e.data);
        chk("result_ovf", longint'(out_ovf), longint'(e.ovf));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);

    // mode 0, len 1, with latency check
    push(70, 1'b0);
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
    repeat (6) @(posedge clk);
    #1 chk("latency_early", out_valid, 0);
    @(posedge clk);
    #1 chk("latency_k7", out_valid, 1);
    drain(4);

    // mode 1 squared differences
    cfg_mode = 1'b1;
    push(158, 1'b0);
    send(pk(10, -3, 0, 5), pk(7, 4, 0, -5));
    drain(12);
    cfg_mode = 1'b0;

    // len 3 group, then a separate len 1 result
    cfg_accum_len = 16'd3;
    push(210, 1'b0);
    repeat (3) send(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
    drain(12);
    cfg_accum_len = 16'd1;
    push(70, 1'b0);
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
    drain(12);

    // backpressure with two results pending
    out_ready = 1'b0;
    push(70, 1'b0);
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8));
    push(4, 1'b0);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    drain(12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 70);
    end
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    drain(12);

    // wrap and overflow at P=40
    cfg_accum_len = 16'd8;
    push(-(64'sd1 <<< 39), 1'b1);
    repeat (8) send(pk(-131072, -131072, -131072, -131072), pk(-131072, -131072, -131072, -131072));
    drain(12);
    cfg_accum_len = 16'd1;
    push(4, 1'b0);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    drain(12);

    // asynchronous reset mid-group
    chk("pre_reset_out_data", out_data, 4);
    cfg_accum_len = 16'd4;
    a = pk(1, 2, 3, 4);
    b = pk(5, 6, 7, 8);
    in_valid = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_data", out_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cfg_accum_len = 16'd1;
    @(negedge clk);
    push(70, 1'b0);
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8));

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("scoreboard_empty", exp_q.size(), 0);
    end
    drain(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
